axi_lite_regfile: RTL and testbench

AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

---
 rtl/axi_lite_pkg.sv | 19 +
 rtl/axi_lite_rd_ctrl.sv | 79 +++++++
 rtl/axi_lite_regfile.sv | 164 ++++++++++++++++
 tb/tb_axi_lite_regfile.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response codes and FSM state types for the register file.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

endpackage

// File: rtl/axi_lite_rd_ctrl.sv
// AXI-Lite read channel: address decode, read-data mux and single-beat R FSM.
module axi_lite_rd_ctrl
  import axi_lite_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH = 8,
  parameter int unsigned          REG_COUNT  = 16,
  parameter logic [REG_COUNT-1:0] RO_MASK    = '0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [ADDR_WIDTH-1:0]                s_axi_araddr,
  input  logic                                 s_axi_arvalid,
  output logic                                 s_axi_arready,
  output logic [DATA_WIDTH-1:0]                s_axi_rdata,
  output logic [1:0]                           s_axi_rresp,
  output logic                                 s_axi_rvalid,
  input  logic                                 s_axi_rready,
  input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] reg_val,
  input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] ro_in,
  output logic [REG_COUNT-1:0]                 rd_pulse
);

  localparam int unsigned IDX_LSB = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_W   = ADDR_WIDTH - IDX_LSB;

  rd_state_e              r_state_q;
  logic [IDX_W-1:0]       ar_idx;
  logic [REG_COUNT-1:0]   rd_hit;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   rd_err;
  logic                   unused_ar_lsb;

  assign ar_idx        = s_axi_araddr[ADDR_WIDTH-1:IDX_LSB];
  assign unused_ar_lsb = ^s_axi_araddr[IDX_LSB-1:0];

  // No match leaves rd_err set: out-of-range index returns zero with SLVERR.
  always_comb begin
    rd_hit  = '0;
    rd_data = '0;
    rd_err  = 1'b1;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_hit[i] = 1'b1;
        rd_err    = 1'b0;
        rd_data   = RO_MASK[i] ? ro_in[i] : reg_val[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_q     <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      rd_pulse      <= '0;
    end else begin
      rd_pulse <= '0;
      if (r_state_q == R_IDLE) begin
        s_axi_arready <= 1'b1;
        if (s_axi_arvalid && s_axi_arready) begin
          r_state_q     <= R_DATA;
          s_axi_arready <= 1'b0;
          s_axi_rvalid  <= 1'b1;
          s_axi_rdata   <= rd_data;
          s_axi_rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
          rd_pulse      <= rd_hit;
        end
      end else if (s_axi_rready) begin
        r_state_q     <= R_IDLE;
        s_axi_rvalid  <= 1'b0;
        s_axi_arready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI-Lite slave register file: write FSM and register array, read path in axi_lite_rd_ctrl.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH = 8,
  parameter int unsigned          REG_COUNT  = 16,
  parameter logic [REG_COUNT-1:0] RO_MASK    = '0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [ADDR_WIDTH-1:0]                s_axi_awaddr,
  input  logic                                 s_axi_awvalid,
  output logic                                 s_axi_awready,
  input  logic [DATA_WIDTH-1:0]                s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]              s_axi_wstrb,
  input  logic                                 s_axi_wvalid,
  output logic                                 s_axi_wready,
  output logic [1:0]                           s_axi_bresp,
  output logic                                 s_axi_bvalid,
  input  logic                                 s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]                s_axi_araddr,
  input  logic                                 s_axi_arvalid,
  output logic                                 s_axi_arready,
  output logic [DATA_WIDTH-1:0]                s_axi_rdata,
  output logic [1:0]                           s_axi_rresp,
  output logic                                 s_axi_rvalid,
  input  logic                                 s_axi_rready,
  input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] reg_default,
  output logic [REG_COUNT-1:0][DATA_WIDTH-1:0] reg_out,
  input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] ro_in,
  output logic [REG_COUNT-1:0]                 wr_pulse,
  output logic [REG_COUNT-1:0]                 rd_pulse
);

  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W   = ADDR_WIDTH - IDX_LSB;

  wr_state_e                            w_state_q, w_state_d;
  logic                                 pend_q, pend_d;
  logic [IDX_W-1:0]                     aw_idx_q;
  logic [DATA_WIDTH-1:0]                wdata_q;
  logic [STRB_W-1:0]                    wstrb_q;
  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] reg_q;
  logic [REG_COUNT-1:0]                 wr_hit;
  logic                                 wr_err;
  logic [DATA_WIDTH-1:0]                wr_mask;
  logic                                 aw_hs, w_hs;
  logic                                 unused_aw_lsb;

  assign aw_hs         = s_axi_awvalid & s_axi_awready;
  assign w_hs          = s_axi_wvalid & s_axi_wready;
  assign unused_aw_lsb = ^s_axi_awaddr[IDX_LSB-1:0];
  assign reg_out       = reg_q;

  // pend marks "address and data both held"; the commit happens on the following edge.
  always_comb begin
    w_state_d = w_state_q;
    pend_d    = pend_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_state_d = W_HAVE_ADDR;
          pend_d    = 1'b1;
        end else if (aw_hs) begin
          w_state_d = W_HAVE_ADDR;
        end else if (w_hs) begin
          w_state_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR, W_HAVE_DATA: begin
        if (pend_q) begin
          w_state_d = W_RESP;
          pend_d    = 1'b0;
        end else if (aw_hs || w_hs) begin
          pend_d = 1'b1;
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // RO and out-of-range targets never hit, so they commit nothing and pulse nothing.
  always_comb begin
    wr_hit = '0;
    wr_err = 1'b1;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (aw_idx_q == IDX_W'(i)) begin
        wr_hit[i] = ~RO_MASK[i];
        wr_err    = RO_MASK[i];
      end
    end
    for (int b = 0; b < STRB_W; b++) begin
      wr_mask[8*b +: 8] = {8{wstrb_q[b]}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q     <= W_IDLE;
      pend_q        <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      wr_pulse      <= '0;
      aw_idx_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      w_state_q     <= w_state_d;
      pend_q        <= pend_d;
      s_axi_awready <= ~pend_d & ((w_state_d == W_IDLE) | (w_state_d == W_HAVE_DATA));
      s_axi_wready  <= ~pend_d & ((w_state_d == W_IDLE) | (w_state_d == W_HAVE_ADDR));
      wr_pulse      <= pend_q ? wr_hit : '0;
      if (aw_hs) aw_idx_q <= s_axi_awaddr[ADDR_WIDTH-1:IDX_LSB];
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (pend_q) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_q <= reg_default;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (pend_q && wr_hit[i]) reg_q[i] <= (reg_q[i] & ~wr_mask) | (wdata_q & wr_mask);
      end
    end
  end

  axi_lite_rd_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .RO_MASK    (RO_MASK)
  ) u_rd_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .reg_val       (reg_q),
    .ro_in         (ro_in),
    .rd_pulse      (rd_pulse)
  );

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Scoreboard bench for axi_lite_regfile: 5 registers, register 3 read-only.
module tb_axi_lite_regfile;
  import axi_lite_pkg::*;

  localparam int unsigned   DW  = 32;
  localparam int unsigned   AW  = 8;
  localparam int unsigned   RC  = 5;
  localparam logic [RC-1:0] ROM = 5'b01000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [3:0] s_axi_wstrb;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic [RC-1:0][DW-1:0] reg_default, reg_out, ro_in;
  logic [RC-1:0] wr_pulse, rd_pulse;

  axi_lite_regfile #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .REG_COUNT  (RC),
    .RO_MASK    (ROM)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .reg_default   (reg_default),
    .reg_out       (reg_out),
    .ro_in         (ro_in),
    .wr_pulse      (wr_pulse),
    .rd_pulse      (rd_pulse)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic [RC-1:0] pulse;
  } rd_exp_t;

  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] mdl [RC];
  logic [RC-1:0] ro_mask_v = ROM;
  logic [1:0]    exp_b [$];
  logic [RC-1:0] exp_wp [$];
  rd_exp_t       exp_r [$];
  logic bv_prev = 1'b0;
  logic rv_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'(a[AW-1:2]);
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
    int idx;
    idx = idx_of(a);
    if (idx >= int'(RC)) return '0;
    if (ro_mask_v[idx]) return ro_in[idx];
    return mdl[idx];
  endfunction

  function automatic logic [1:0] exp_resp(input logic [AW-1:0] a, input bit is_wr);
    int idx;
    idx = idx_of(a);
    if (idx >= int'(RC)) return RESP_SLVERR;
    if (is_wr && ro_mask_v[idx]) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  task automatic check_regs();
    for (int i = 0; i < int'(RC); i++) check_eq($sformatf("reg_out[%0d]", i), reg_out[i], mdl[i]);
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int stall);
    int idx;
    int cnt;
    logic [1:0] resp;
    logic [RC-1:0] pulse;
    idx   = idx_of(addr);
    resp  = exp_resp(addr, 1'b1);
    pulse = '0;
    if (resp == RESP_OKAY) begin
      pulse[idx] = 1'b1;
      for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
    end
    exp_b.push_back(resp);
    exp_wp.push_back(pulse);
    if (stall > 0) s_axi_bready = 1'b0;
    fork
      begin
        int n;
        n = 0;
        repeat (aw_dly) begin @(posedge clk); #1; end
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!s_axi_awready && n < 50);
        check_eq("aw_ready", s_axi_awready, 1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
      end
      begin
        int n;
        n = 0;
        repeat (w_dly) begin @(posedge clk); #1; end
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        s_axi_wvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!s_axi_wready && n < 50);
        check_eq("w_ready", s_axi_wready, 1);
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0;
      end
    join
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!s_axi_bvalid && cnt < 50);
    check_eq("b_latency", 64'(cnt), 2);
    if (stall > 0) begin
      repeat (stall) begin
        @(negedge clk);
        check_eq("b_hold_valid", s_axi_bvalid, 1);
        check_eq("b_hold_resp", s_axi_bresp, resp);
        check_eq("aw_blocked", s_axi_awready, 0);
        check_eq("w_blocked", s_axi_wready, 0);
      end
      @(posedge clk); #1;
      s_axi_bready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int dly, input int stall,
                          input logic [DW-1:0] edata, input logic [1:0] eresp);
    rd_exp_t e;
    int idx;
    int n;
    idx     = idx_of(addr);
    e.data  = edata;
    e.resp  = eresp;
    e.pulse = '0;
    if (idx < int'(RC)) e.pulse[idx] = 1'b1;
    exp_r.push_back(e);
    if (stall > 0) s_axi_rready = 1'b0;
    repeat (dly) begin @(posedge clk); #1; end
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_arready && n < 50);
    check_eq("ar_ready", s_axi_arready, 1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    @(negedge clk);
    check_eq("r_latency", s_axi_rvalid, 1);
    if (stall > 0) begin
      repeat (stall) begin
        @(negedge clk);
        check_eq("r_hold_valid", s_axi_rvalid, 1);
        check_eq("r_hold_data", s_axi_rdata, edata);
        check_eq("r_hold_resp", s_axi_rresp, eresp);
        check_eq("ar_blocked", s_axi_arready, 0);
      end
      @(posedge clk); #1;
      s_axi_rready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard side: pops expectations as the DUT presents responses and pulses.
  always @(negedge clk) begin
    if (s_axi_bvalid && s_axi_bready) begin
      if (exp_b.size() == 0) check_eq("b_unexpected", s_axi_bvalid, 0);
      else check_eq("bresp", s_axi_bresp, exp_b.pop_front());
    end
    if (s_axi_bvalid && !bv_prev) begin
      if (exp_wp.size() == 0) check_eq("wr_pulse_unexp", wr_pulse, 0);
      else check_eq("wr_pulse", wr_pulse, exp_wp.pop_front());
    end else if (wr_pulse != '0) begin
      check_eq("wr_pulse_stray", wr_pulse, 0);
    end
    if (s_axi_rvalid && !rv_prev) begin
      if (exp_r.size() == 0) check_eq("rd_pulse_unexp", rd_pulse, 0);
      else check_eq("rd_pulse", rd_pulse, exp_r[0].pulse);
    end else if (rd_pulse != '0) begin
      check_eq("rd_pulse_stray", rd_pulse, 0);
    end
    if (s_axi_rvalid && s_axi_rready) begin
      if (exp_r.size() == 0) begin
        check_eq("r_unexpected", s_axi_rvalid, 0);
      end else begin
        check_eq("rdata", s_axi_rdata, exp_r[0].data);
        check_eq("rresp", s_axi_rresp, exp_r[0].resp);
        void'(exp_r.pop_front());
      end
    end
    bv_prev <= s_axi_bvalid;
    rv_prev <= s_axi_rvalid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] old;
    int n;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    for (int i = 0; i < int'(RC); i++) begin
      reg_default[i] = 32'hA5A5_0000 | DW'(i);
      ro_in[i]       = 32'h0BAD_0000 | DW'(i);
    end
    reg_default[2] = 32'h1234_5678;
    ro_in[3]       = 32'hCAFE_0001;
    for (int i = 0; i < int'(RC); i++) mdl[i] = reg_default[i];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_awready", s_axi_awready, 0);
    check_eq("rst_wready", s_axi_wready, 0);
    check_eq("rst_arready", s_axi_arready, 0);
    check_eq("rst_bvalid", s_axi_bvalid, 0);
    check_eq("rst_rvalid", s_axi_rvalid, 0);
    check_eq("rst_bresp", s_axi_bresp, 0);
    check_eq("rst_rresp", s_axi_rresp, 0);
    check_eq("rst_rdata", s_axi_rdata, 0);
    check_eq("rst_wr_pulse", wr_pulse, 0);
    check_eq("rst_rd_pulse", rd_pulse, 0);
    check_regs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("idle_awready", s_axi_awready, 1);
    check_eq("idle_wready", s_axi_wready, 1);
    check_eq("idle_arready", s_axi_arready, 1);
    @(posedge clk); #1;

    // AW and W together, then W three cycles ahead of AW, then AW ahead of W.
    axi_write(8'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    check_regs();
    axi_write(8'h08, 32'h0000_00AA, 4'h1, 3, 0, 0);
    check_eq("req024_reg2", reg_out[2], 32'h1234_56AA);
    axi_write(8'h00, 32'h0102_0304, 4'hF, 0, 2, 0);
    check_regs();
    axi_read(8'h04, 0, 0, exp_rdata(8'h04), exp_resp(8'h04, 1'b0));
    axi_read(8'h08, 0, 0, exp_rdata(8'h08), exp_resp(8'h08, 1'b0));

    // Low address bits ignored; partial strobes.
    axi_write(8'h07, 32'h7777_0000, 4'hC, 0, 0, 0);
    check_regs();
    axi_read(8'h05, 0, 0, exp_rdata(8'h05), exp_resp(8'h05, 1'b0));

    // Out of range and read-only.
    axi_write(8'h18, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_write(8'h14, 32'hFFFF_FFFF, 4'hF, 1, 0, 0);
    check_regs();
    axi_read(8'h18, 0, 0, 32'h0, RESP_SLVERR);
    axi_write(8'h0C, 32'h1111_1111, 4'hF, 0, 0, 0);
    check_regs();
    axi_read(8'h0C, 0, 0, 32'hCAFE_0001, RESP_OKAY);

    // Read sampled on the commit edge of a write to the same register.
    old = mdl[0];
    fork
      axi_write(8'h00, 32'h55AA_55AA, 4'hF, 0, 0, 0);
      axi_read(8'h00, 1, 0, old, RESP_OKAY);
    join
    check_regs();
    axi_read(8'h00, 0, 0, exp_rdata(8'h00), RESP_OKAY);

    // Both responses back-pressured for five cycles.
    fork
      axi_write(8'h10, 32'h0BAD_F00D, 4'hF, 0, 0, 5);
      axi_read(8'h08, 0, 5, exp_rdata(8'h08), RESP_OKAY);
    join
    check_regs();

    // Reset after AW accepted, before W.
    s_axi_awaddr  = 8'h04;
    s_axi_awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_awready && n < 50);
    check_eq("mid_aw_ready", s_axi_awready, 1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("mid_rst_awready", s_axi_awready, 0);
    check_eq("mid_rst_wready", s_axi_wready, 0);
    check_eq("mid_rst_bvalid", s_axi_bvalid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < int'(RC); i++) mdl[i] = reg_default[i];
    repeat (4) begin
      @(negedge clk);
      check_eq("mid_no_bvalid", s_axi_bvalid, 0);
    end
    check_regs();
    @(posedge clk); #1;
    axi_write(8'h04, 32'h1122_3344, 4'h5, 0, 0, 0);
    check_regs();
    axi_read(8'h04, 0, 0, exp_rdata(8'h04), RESP_OKAY);

    repeat (3) @(posedge clk);
    check_eq("b_queue_empty", 64'(exp_b.size()), 0);
    check_eq("r_queue_empty", 64'(exp_r.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
